// File: rtl/pipe_stage_skid_reg_if.sv
// Handshake bundle for one side of an elastic pipeline stage: valid/ready
// plus the payload of operand lanes, register specifiers and control bits.
interface pipe_stage_skid_reg_if #(
  parameter int NUM_OPS  = 2,
  parameter int OP_W     = 64,
  parameter int NUM_REGS = 3,
  parameter int REG_W    = 5,
  parameter int CTRL_W   = 11
);
  logic                      valid;
  logic                      ready;
  logic [NUM_OPS*OP_W-1:0]   ops;
  logic [NUM_REGS*REG_W-1:0] regs;
  logic [CTRL_W-1:0]         ctrl;

  // Producer side drives the beat, consumer side answers with ready
  modport master (output valid, ops, regs, ctrl, input ready);
  modport slave  (input valid, ops, regs, ctrl, output ready);
endinterface

// File: rtl/pipe_stage_skid_reg.sv
// Elastic pipeline-stage register with a 2-entry skid buffer, flush and
// bubble insertion. in_ready is decoded from state only, so a downstream
// stall never forms a combinational path back to the upstream stage.
module pipe_stage_skid_reg #(
  parameter int NUM_OPS  = 2,
  parameter int OP_W     = 64,
  parameter int NUM_REGS = 3,
  parameter int REG_W    = 5,
  parameter int CTRL_W   = 11
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  pipe_stage_skid_reg_if.slave    up,
  pipe_stage_skid_reg_if.master   dn,
  output logic [1:0]              occupancy
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [NUM_OPS*OP_W-1:0]   main_ops;
  logic [NUM_REGS*REG_W-1:0] main_regs;
  logic [CTRL_W-1:0]         main_ctrl;
  logic [NUM_OPS*OP_W-1:0]   skid_ops;
  logic [NUM_REGS*REG_W-1:0] skid_regs;
  logic [CTRL_W-1:0]         skid_ctrl;

  logic accept;
  logic pop;
  logic load_main_in;
  logic load_main_skid;
  logic load_skid_in;
  logic clear_main_ctrl;
  logic clear_skid_ctrl;

  // Main holds a beat in ONE and FULL; skid only in FULL
  assign up.ready  = (state != FULL);
  assign dn.valid  = (state != EMPTY);
  assign dn.ops    = main_ops;
  assign dn.regs   = main_regs;
  assign dn.ctrl   = main_ctrl;
  assign occupancy = state;

  assign accept = up.valid & up.ready;
  assign pop    = dn.valid & dn.ready;

  // State register; reset returns the stage to EMPTY
  always_ff @(posedge clk) begin
    if (reset) state <= EMPTY;
    else       state <= state_next;
  end

  // Next state and entry load/clear strobes; flush empties the stage and drops any accepted beat
  always_comb begin
    state_next      = state;
    load_main_in    = 1'b0;
    load_main_skid  = 1'b0;
    load_skid_in    = 1'b0;
    clear_main_ctrl = 1'b0;
    clear_skid_ctrl = 1'b0;
    if (flush) begin
      state_next      = EMPTY;
      clear_main_ctrl = 1'b1;
      clear_skid_ctrl = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            state_next   = ONE;
            load_main_in = 1'b1;
          end
        end
        ONE: begin
          if (accept && pop) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            state_next   = FULL;
            load_skid_in = 1'b1;
          end else if (pop) begin
            state_next      = EMPTY;
            clear_main_ctrl = 1'b1;
          end
        end
        FULL: begin
          if (pop) begin
            state_next      = ONE;
            load_main_skid  = 1'b1;
            clear_skid_ctrl = 1'b1;
          end
        end
        default: begin
          state_next = EMPTY;
        end
      endcase
    end
  end

  // Payload storage; a vacated entry has its ctrl zeroed so an empty stage emits a bubble
  always_ff @(posedge clk) begin
    if (reset) begin
      main_ops  <= '0;
      main_regs <= '0;
      main_ctrl <= '0;
      skid_ops  <= '0;
      skid_regs <= '0;
      skid_ctrl <= '0;
    end else begin
      if (load_main_in) begin
        main_ops  <= up.ops;
        main_regs <= up.regs;
        main_ctrl <= up.ctrl;
      end else if (load_main_skid) begin
        main_ops  <= skid_ops;
        main_regs <= skid_regs;
        main_ctrl <= skid_ctrl;
      end
      if (load_skid_in) begin
        skid_ops  <= up.ops;
        skid_regs <= up.regs;
        skid_ctrl <= up.ctrl;
      end
      if (clear_main_ctrl) main_ctrl <= '0;
      if (clear_skid_ctrl) skid_ctrl <= '0;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Bench for pipe_stage_skid_reg: a default-width instance and a narrow
// instance share the same handshake stimulus and are both compared against
// a queue-based model of the stage.
module tb_pipe_stage_skid_reg;

  typedef struct packed {
    logic [127:0] ops;
    logic [14:0]  regs;
    logic [10:0]  ctrl;
  } beat_t;

  logic       clk = 1'b0;
  logic       reset;
  logic       flush;
  logic [1:0] occ_b;
  logic [1:0] occ_s;

  int checks = 0;
  int errors = 0;

  beat_t q[$];
  beat_t main_b;

  pipe_stage_skid_reg_if up_b ();
  pipe_stage_skid_reg_if dn_b ();
  pipe_stage_skid_reg_if #(.NUM_OPS(1), .OP_W(32), .NUM_REGS(1), .REG_W(5), .CTRL_W(3)) up_s ();
  pipe_stage_skid_reg_if #(.NUM_OPS(1), .OP_W(32), .NUM_REGS(1), .REG_W(5), .CTRL_W(3)) dn_s ();

  pipe_stage_skid_reg dut_b (
    .clk(clk), .reset(reset), .flush(flush),
    .up(up_b), .dn(dn_b), .occupancy(occ_b)
  );

  pipe_stage_skid_reg #(.NUM_OPS(1), .OP_W(32), .NUM_REGS(1), .REG_W(5), .CTRL_W(3)) dut_s (
    .clk(clk), .reset(reset), .flush(flush),
    .up(up_s), .dn(dn_s), .occupancy(occ_s)
  );

  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input beat_t b, input logic v, input logic r,
                                input logic f, input logic rs);
    reset      = rs;
    flush      = f;
    up_b.valid = v;
    up_b.ops   = b.ops;
    up_b.regs  = b.regs;
    up_b.ctrl  = b.ctrl;
    dn_b.ready = r;
    up_s.valid = v;
    up_s.ops   = b.ops[31:0];
    up_s.regs  = b.regs[4:0];
    up_s.ctrl  = b.ctrl[2:0];
    dn_s.ready = r;
  endtask

  task automatic check_output();
    beat_t exp;
    logic  ev;
    ev  = (q.size() > 0);
    exp = ev ? q[0] : main_b;
    if (!ev) exp.ctrl = '0;
    check_value("big.out_valid", 128'(dn_b.valid), 128'(ev));
    check_value("big.out_ops",   128'(dn_b.ops),   exp.ops);
    check_value("big.out_regs",  128'(dn_b.regs),  128'(exp.regs));
    check_value("big.out_ctrl",  128'(dn_b.ctrl),  128'(exp.ctrl));
    check_value("big.in_ready",  128'(up_b.ready), 128'(q.size() < 2));
    check_value("big.occupancy", 128'(occ_b),      128'(q.size()));
    check_value("small.out_valid", 128'(dn_s.valid), 128'(ev));
    check_value("small.out_ops",   128'(dn_s.ops),   128'(exp.ops[31:0]));
    check_value("small.out_regs",  128'(dn_s.regs),  128'(exp.regs[4:0]));
    check_value("small.out_ctrl",  128'(dn_s.ctrl),  128'(exp.ctrl[2:0]));
    check_value("small.in_ready",  128'(up_s.ready), 128'(q.size() < 2));
    check_value("small.occupancy", 128'(occ_s),      128'(q.size()));
  endtask

  // One clock: drive, check before the edge, then advance the model across the edge
  task automatic step(input beat_t b, input logic v, input logic r,
                      input logic f, input logic rs);
    logic acc;
    logic pp;
    apply_stimulus(b, v, r, f, rs);
    @(negedge clk);
    check_output();
    acc = v && (q.size() < 2);
    pp  = (q.size() > 0) && r;
    @(posedge clk);
    if (rs) begin
      q.delete();
      main_b = '0;
    end else if (f) begin
      q.delete();
    end else begin
      if (pp) void'(q.pop_front());
      if (acc) q.push_back(b);
      if (q.size() > 0) main_b = q[0];
    end
    #1;
  endtask

  function automatic beat_t mk(input int unsigned a, input logic [14:0] rg, input logic [10:0] c);
    beat_t b;
    b.ops  = {64'(a + 100), 64'(a)};
    b.regs = rg;
    b.ctrl = c;
    return b;
  endfunction

  function automatic beat_t rnd();
    beat_t b;
    b.ops  = {$urandom(), $urandom(), $urandom(), $urandom()};
    b.regs = 15'($urandom());
    b.ctrl = 11'($urandom());
    return b;
  endfunction

  initial begin
    beat_t z;
    z = '0;
    apply_stimulus(z, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    q.delete();
    main_b = '0;

    // reset release: first checked cycle shows reset values
    step(z, 1'b0, 1'b1, 1'b0, 1'b0);

    // streaming, 4 beats back to back
    for (int i = 0; i < 4; i++)
      step(mk(i, {5'd3, 5'd2, 5'd1}, 11'h7FF), 1'b1, 1'b1, 1'b0, 1'b0);
    step(z, 1'b0, 1'b1, 1'b0, 1'b0);
    step(z, 1'b0, 1'b1, 1'b0, 1'b0);

    // stall and skid: A, B, C with out_ready low from A's output cycle
    step(mk(10, 15'h0421, 11'h111), 1'b1, 1'b1, 1'b0, 1'b0);
    step(mk(11, 15'h0842, 11'h222), 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(12, 15'h0C63, 11'h333), 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(12, 15'h0C63, 11'h333), 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(12, 15'h0C63, 11'h333), 1'b1, 1'b1, 1'b0, 1'b0);
    step(mk(12, 15'h0C63, 11'h333), 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (3) step(z, 1'b0, 1'b1, 1'b0, 1'b0);

    // bubble after a single beat
    step(mk(20, 15'h1234, 11'h0A5), 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) step(z, 1'b0, 1'b1, 1'b0, 1'b0);

    // flush while FULL with a simultaneous incoming beat
    step(mk(30, 15'h0001, 11'h5A5), 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(31, 15'h0002, 11'h2AA), 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(32, 15'h0003, 11'h7F0), 1'b1, 1'b1, 1'b1, 1'b0);
    repeat (2) step(z, 1'b0, 1'b1, 1'b0, 1'b0);

    // reset mid-operation together with flush and in_valid
    step(mk(40, 15'h0011, 11'h0F0), 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(41, 15'h0022, 11'h00F), 1'b1, 1'b0, 1'b0, 1'b0);
    step(mk(42, 15'h0033, 11'h3C3), 1'b1, 1'b0, 1'b1, 1'b1);
    step(mk(43, 15'h0044, 11'h555), 1'b1, 1'b1, 1'b0, 1'b0);
    repeat (2) step(z, 1'b0, 1'b1, 1'b0, 1'b0);

    // randomized traffic with occasional flush and reset
    for (int i = 0; i < 400; i++)
      step(rnd(), 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 31) == 0), 1'($urandom_range(0, 99) == 0));

    // drain
    repeat (4) step(z, 1'b0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid_reg.md
# pipe_stage_skid_reg

Parametrised elastic pipeline-stage register. It replaces the fixed-width, always-advancing inter-stage registers (IF/ID, ID/EX, EX/MEM, MEM/WB) with one block per boundary. Each instance carries operand lanes, register specifiers and control bits, and adds a valid/ready handshake, a 2-entry skid buffer, flush, and bubble insertion (control zeroed when empty). Stalls apply backpressure with no combinational path from `out_ready` to `in_ready`.

## Interface
Parameters:
- `NUM_OPS`, 2, number of operand lanes
- `OP_W`, 64, width of each operand lane
- `NUM_REGS`, 3, number of register-specifier fields (e.g. Rn, Rm, Rd)
- `REG_W`, 5, width of each register specifier
- `CTRL_W`, 11, control-bit width (8 single-bit controls plus 3-bit ALUOp in the ID/EX instance)

Ports:
- `clk`  in  1  clock; all state updates on the rising edge
- `reset`  in  1  synchronous, active-high reset
- `flush`  in  1  synchronous pipeline flush
- `in_valid`  in  1  upstream beat present
- `in_ready`  out  1  stage can accept; a function of state registers only
- `in_ops`  in  NUM_OPS*OP_W  operand lanes, lane 0 in the LSBs
- `in_regs`  in  NUM_REGS*REG_W  register specifiers, field 0 in the LSBs
- `in_ctrl`  in  CTRL_W  control bits
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  downstream accepts; low = stall
- `out_ops`, `out_regs`, `out_ctrl`  out  same widths as the inputs  head-entry payload
- `occupancy`  out  2  entries held, 0..2

## Operation
- Storage: a main entry (drives the outputs) and a skid entry. Each entry holds a valid bit plus ops, regs and ctrl.
- Definitions: accept = `in_valid & in_ready`; pop = `out_valid & out_ready`.
- `in_ready` = NOT skid-valid. `out_valid` = main-valid.
- States: EMPTY (occupancy 0), ONE (1), FULL (2).
- EMPTY:
  - accept -> ONE; main <= in.
- ONE:
  - accept & pop -> ONE; main <= in.
  - accept & !pop -> FULL; skid <= in.
  - !accept & pop -> EMPTY.
  - otherwise hold.
- FULL (`in_ready`=0):
  - pop -> ONE; main <= skid, skid ctrl cleared.
  - otherwise hold.
- Bubble rule: whenever an entry becomes invalid, its ctrl field is cleared to 0, so `out_ctrl`=0 whenever `out_valid`=0. `out_ops` and `out_regs` retain their last loaded value (0 after reset).
- Flush:
  - Next state is EMPTY; both valid bits and ctrl fields are cleared.
  - A beat accepted in the flush cycle is dropped. Upstream still sees the handshake complete.
  - A pop in the flush cycle counts as a completed transfer.
- Reset priority: reset > flush > normal transitions.
  - Reset clears every register to 0 and sets state EMPTY.
  - Beats presented during reset are dropped.
- Data order is strict FIFO; the skid entry never overtakes main.

## Timing
- Reset values: `out_valid`=0, `out_ops`=0, `out_regs`=0, `out_ctrl`=0, `occupancy`=0, `in_ready`=1 from the first cycle after reset deasserts.
- Latency: a beat accepted at edge N appears on the outputs after edge N (1 cycle) when the stage is EMPTY or popping.
- Throughput: 1 beat/cycle sustained with `out_ready`=1.
- Stall response: after `out_ready` falls, one further beat is absorbed (into skid); `in_ready` falls after that edge.
- Stall release: `in_ready` returns 1 the cycle after the first pop from FULL.
- `in_ready` and all outputs are registered or decoded from registers only; there is no input-to-output combinational path.
- Flush is effective at the next edge: `out_valid`=0 and `out_ctrl`=0 in the following cycle.

## Test plan
- Streaming: reset, then 4 beats ops={i, i+100}, regs={1,2,3}, ctrl=11'h7FF, `out_ready`=1 -> outputs match each beat 1 cycle later; occupancy stays 1; `in_ready` never drops.
- Stall and skid:
  - Beats A, B, C; `out_ready`=0 from A's output cycle -> B lands in skid, occupancy=2, `in_ready`=0, C held upstream.
  - Raise `out_ready` -> A, B, C leave in order with no loss or duplication.
- Bubble: single beat ctrl=11'h0A5 popped, then no input -> next cycle `out_valid`=0, `out_ctrl`=0, `out_ops` still equals the last beat.
- Flush in FULL with a simultaneous `in_valid` -> next cycle occupancy=0, `out_valid`=0, `out_ctrl`=0, `in_ready`=1; the flushed beats never appear.
- Reset mid-operation: FULL state, assert `reset` together with `flush` and `in_valid` -> all outputs 0, occupancy=0; the first beat after reset appears 1 cycle after acceptance.
- Parameter sweep: `NUM_OPS`=1, `OP_W`=32, `NUM_REGS`=1, `CTRL_W`=3, rerun the streaming and stall tests against a scoreboard -> bit-exact order and contents.
